// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
// Radix-2 shift/add multiply and restoring divide on operand magnitudes,
// with a final sign correction. Divide-by-zero and signed overflow
// complete straight from IDLE.
// Optional macro MDU_FAST_MUL_EN: MUL* ops use a single-cycle combinational
// multiply (latency 1); division is unchanged and results are bit-identical.
module mdu_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic                  wr_en
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_d;
  logic [ADDR_WIDTH-1:0] rd_d;
  logic              done_d, wr_en_d, busy_d;

  // Sign handling of the incoming request
  logic            is_mul_in, a_sgn_in, b_sgn_in, neg_a, neg_b, neg_res_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;

  // Applies sign correction and selects the architectural result
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] f3,
                                               input logic neg,
                                               input logic [PW-1:0] p);
    logic [PW-1:0]   full;
    logic [XLEN-1:0] qq, rr, res;
    full = neg ? -p : p;
    qq   = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
    rr   = neg ? -p[PW-1:XLEN] : p[PW-1:XLEN];
    if (!f3[2]) res = (f3[1:0] == 2'b00) ? full[XLEN-1:0] : full[PW-1:XLEN];
    else        res = f3[1] ? rr : qq;
    return res;
  endfunction

  // Operand decode: signedness, magnitudes and special-case detection
  always_comb begin
    is_mul_in  = !funct3[2];
    a_sgn_in   = is_mul_in ? (funct3[1:0] != 2'b11) : !funct3[0];
    b_sgn_in   = is_mul_in ? !funct3[1] : !funct3[0];
    neg_a      = a_sgn_in & src_a[XLEN-1];
    neg_b      = b_sgn_in & src_b[XLEN-1];
    a_mag      = neg_a ? -src_a : src_a;
    b_mag      = neg_b ? -src_b : src_b;
    neg_res_in = (!is_mul_in && funct3[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero   = !is_mul_in && (src_b == '0);
    div_ovf    = !is_mul_in && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
    if (div_zero) spec_res = funct3[1] ? src_a : '1;
    else          spec_res = funct3[1] ? '0 : MIN_NEG;
  end

`ifdef MDU_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  // Single-cycle magnitude product
  always_comb fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  // One radix-2 iteration of multiply or restoring divide
  logic [XLEN:0]   mul_sum, rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_new;
  logic [PW-1:0]   step;
  always_comb begin
    mul_sum = {1'b0, p_q[PW-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {p_q[PW-1:XLEN], p_q[XLEN-1]};
    ge      = rem_sh >= {1'b0, b_q};
    rem_new = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
    step    = f3_q[2] ? {rem_new, p_q[XLEN-2:0], ge}
                      : {mul_sum, p_q[XLEN-1:1]};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result;
    rd_d     = rd_out;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          f3_d = funct3;
          rd_d = rd_in;
          if (div_zero || div_ovf) begin
            result_d = spec_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (is_mul_in) begin
            result_d = finalize(funct3, neg_res_in, fast_prod);
            done_d   = 1'b1;
            state_d  = DONE;
          end
`endif
          else begin
            p_d     = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            neg_d   = neg_res_in;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = finalize(f3_q, neg_q, step);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    wr_en_d = done_d && (rd_d != '0);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      result  <= result_d;
      rd_out  <= rd_d;
      done    <= done_d;
      wr_en   <= wr_en_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter against an
// arithmetic reference model (64-bit integer math on the RV32M rules).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter #(.XLEN(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin sp = sa * sb; return 32'(sp); end
      3'd1: begin sp = sa * sb; return 32'(sp >>> 32); end
      3'd2: begin sp = sa * longint'(ub); return 32'(sp >>> 32); end
      3'd3: begin up = ua * ub; return 32'(up >> 32); end
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 32'd0) ? a : 32'(sa % sb);
      default: return (b == 32'd0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op from IDLE, check latency, result, rd and write strobe
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom);
    funct3 = 3'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    check({tag, " wr_en"}, 32'(wr_en), 32'(rd != 5'd0));
    @(posedge clk); #1;
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " done after"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick(input bit is_b);
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'h0000_0000;
      2: return 32'hFFFF_FFFF;
      3: return is_b ? 32'd1 : 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, ndone, d1, d2, guard;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] held_exp;

    rst = 1'b1; start = 1'b0; funct3 = '0; src_a = '0; src_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived expectations
    do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    do_op("MULH", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
    do_op("MULHSU", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000);
    do_op("MULHU", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF);
    do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
    do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
    do_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    do_op("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

    // Start held high with rd=0: one done per accept, re-accept in cycle 34
    a = $urandom;
    b = $urandom | 32'd1;
    held_exp = ref_res(3'd5, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; src_a = a; src_b = b; rd_in = 5'd0;
    @(posedge clk); #1;
    cyc = 1; ndone = 0; d1 = 0; d2 = 0;
    while (cyc <= 70) begin
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = cyc;
        if (ndone == 2) d2 = cyc;
        check("held wr_en rd0", 32'(wr_en), 32'd0);
        check("held result", result, held_exp);
      end
      if (cyc == 34) check("held busy c34", 32'(busy), 32'd0);
      if (cyc == 35) check("held busy c35", 32'(busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check("held done count", 32'(ndone), 32'd2);
    check("held first done", 32'(d1), 32'd33);
    check("held second done", 32'(d2), 32'd67);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("held drain", 32'(busy), 32'd0);

    // Reset in cycle 10 of a DIV drops the op
    do_op("DIVU pre-rst", 3'd5, 32'd100, 32'd7, 5'd13, 32'd14);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; src_a = $urandom; src_b = $urandom | 32'd3; rd_in = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || wr_en) ndone++;
    end
    check("rst no done", 32'(ndone), 32'd0);
    a = $urandom; b = $urandom;
    do_op("MULHU post-rst", 3'd3, a, b, 5'd21, ref_res(3'd3, a, b));

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick(1'b0);
      b = pick(1'b1);
      do_op("rand", f, a, b, 5'($urandom), ref_res(f, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports and feeding its write port. It latches the two source operands (busA/busB) plus destination index on `start`. It computes all eight M-extension operations with a radix-2 shift/add or restoring-division datapath. It then presents the 32-bit result together with a one-cycle register-file write strobe.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `ADDR_WIDTH`, 5: destination register index width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a`  in  XLEN  rs1 value (busA).
- `src_b`  in  XLEN  rs2 value (busB).
- `rd_in`  in  ADDR_WIDTH  destination index.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; `result`/`rd_out` valid.
- `result`  out  XLEN  registered result; holds until next completion.
- `rd_out`  out  ADDR_WIDTH  latched destination index.
- `wr_en`  out  1  = `done` && `rd_out` != 0; drives RegWr.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=1: latch funct3, operands, rd_in.
  - Special case: go to DONE.
  - Otherwise: load the datapath, set cnt=0, and go to CALC.
- CALC:
  - One iteration per cycle; cnt increments.
  - At cnt=31, apply sign correction, register `result`, and go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `start` in DONE is ignored; the upstream must hold the request until `busy`=0.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
- Datapath:
  - The core operates on magnitudes: 64-bit product, 32-bit quotient/remainder.
  - Final negation is applied when the operand signs differ (product/quotient) or the dividend is negative (remainder).
- Results:
  - MUL returns product[31:0].
  - MULH/MULHSU/MULHU return product[63:32].
- Special cases, resolved from IDLE with no CALC phase:
  - Divide by zero: DIV/DIVU = 32'hFFFF_FFFF; REM/REMU = src_a.
  - Signed overflow (src_a=32'h8000_0000, src_b=32'hFFFF_FFFF): DIV = 32'h8000_0000, REM = 0.
- All arithmetic is modulo 2^32 on the result; no exceptions or flags.
- Writes to x0 produce `done` but never `wr_en`. This prevents a same-edge conflict with the register file's x0 clear.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `wr_en`=0, `result`=0, `rd_out`=0, cnt=0.
- `start` accepted on edge E0 (cycle 0 sampled in IDLE).
- Normal op:
  - CALC occupies cycles 1..32.
  - `done` is high in cycle 33; `busy` is low in cycle 34.
  - Latency: 33 cycles start-to-done.
- Special case: `done` in cycle 1; latency 1.
- Back-to-back: next `start` is accepted in cycle 34 at the earliest (cycle 2 for special cases).
- Operand inputs may change freely after the accepting edge.
- `rst` mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight op is dropped with no `done` or `wr_en`.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MUL* ops use a single-cycle 64-bit combinational multiply and go IDLE→DONE directly, giving latency 1.
  - Division is unchanged.
- Not defined: all multiplies use the 32-cycle shift-add path; no `*` operator is synthesized.
- Results must be bit-identical in both builds; only latency differs.

## Test plan
- MUL 7 × -3 (src_b=32'hFFFF_FFFD), rd=5 -> `result`=32'hFFFF_FFEB, `wr_en`=1, `rd_out`=5. `done` in cycle 33, or cycle 1 with `MDU_FAST_MUL_EN`.
- MULH/MULHSU/MULHU with src_a=32'h8000_0000, src_b=32'hFFFF_FFFF -> 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF respectively.
- DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, each with `done` in cycle 1. DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM of the same -> 0.
- `start` held high through an op plus rd=0 -> exactly one `done` per accepted op, second accept in cycle 34, and `wr_en`=0 for rd=0.
- Assert `rst` in cycle 10 of a DIV -> `busy`/`done`/`wr_en`/`result` = 0 immediately. A new MULHU issued after release completes correctly.
